sysctrl_master: RTL and testbench
=================================

SYSCTRL_MASTER -- requirements
Module: sysctrl_master

Interface
REQ-001 Parameter GAP, default 4, clk cycles from each byte strobe to the next strobe or to response capture; legal range 2..15.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request a command frame; consumed when req_valid&req_ready.
REQ-005 req_ready  out  1  high only in IDLE with no autonomous poll starting that cycle.
REQ-006 req_cmd  in  8  command byte, sampled at handshake.
REQ-007 req_len  in  4  payload byte count 0..8, sampled at handshake; values >8 clamp to 8.
REQ-008 pl_we / pl_addr[2:0] / pl_wdata[7:0]  in  1/3/8  payload buffer write port; ignored while busy.
REQ-009 rsp_addr  in  3  response buffer read address.
REQ-010 rsp_rdata  out  8  combinational read of response buffer entry rsp_addr.
REQ-011 tx_strobe  out  1  one-cycle byte strobe toward the responder.
REQ-012 tx_start  out  1  high with tx_strobe on the command byte only.
REQ-013 tx_data  out  8  byte to the responder, valid while tx_strobe is high.
REQ-014 rx_data  in  8  responder's returned byte.
REQ-015 busy  out  1  high from handshake (or poll start) until done.
REQ-016 done  out  1  one-cycle pulse when a frame completes.
REQ-017 int_n  in  1  responder interrupt line, active low (used only with the IRQ poll feature).
REQ-018 irq_status  out  8  last captured interrupt status byte.
REQ-019 irq_valid  out  1  one-cycle pulse when irq_status updates.

Function
REQ-020 States: IDLE, CMD, WAIT, DATA, CAPT, FIN.
REQ-021 IDLE->CMD on handshake: latch cmd/len, set busy; the next cycle drives tx_strobe=1, tx_start=1, tx_data=cmd.
REQ-022 CMD->WAIT: a down-counter loads GAP-1; no response is captured for the command byte.
REQ-023 WAIT expiry: if the payload index k is less than len, go to DATA; otherwise go to FIN.
REQ-024 DATA: one cycle with tx_strobe=1, tx_start=0, tx_data=payload[k]; then wait GAP-1 cycles and go to CAPT.
REQ-025 CAPT: rsp[k] <= rx_data, k <= k+1, then return to the WAIT/DATA decision after a 0-cycle wait, so that consecutive strobes are exactly GAP cycles apart.
REQ-026 FIN: done=1 for one cycle, busy=0, return to IDLE; req_ready may be high the next cycle.
REQ-027 len=0: frame = command strobe only; done occurs GAP+1 cycles after the handshake.
REQ-028 Strobe spacing is exactly GAP cycles for every byte in a frame; tx_strobe never asserts on adjacent cycles.
REQ-029 Response entries at index >= len keep their prior values.
REQ-030 Payload writes while busy are dropped; the frame uses the payload snapshot present at handshake (buffer copied or writes blocked).
REQ-031 tx_data is 8'h00 whenever tx_strobe is low.

Reset
REQ-032 On reset, the following SHALL take effect on the next edge: state=IDLE, busy=0, done=0, tx_strobe=0, tx_start=0, tx_data=0, irq_status=0, irq_valid=0, and the response and payload buffers cleared to 0.
REQ-033 Reset mid-frame aborts the frame immediately with no further strobes and no done pulse.

Configuration
REQ-034 Macro SYSCTRL_MASTER_IRQPOLL_EN.
REQ-035 Defined: when in IDLE with int_n=0 and req_valid=0, the block autonomously issues cmd 8'h05 with len=1 and payload=irq_status (acknowledging the previously seen bits); the captured byte loads irq_status and pulses irq_valid together with done.
REQ-036 Defined: user requests have priority over polls; a poll starts no sooner than GAP cycles after the previous done.
REQ-037 Not defined: int_n is ignored, irq_status/irq_valid are tied to 0, and no autonomous frames are issued.

Verification
REQ-038 GAP=4, cmd=0x00, len=3, responder returns 5C/42/02 -> strobes at t, t+4, t+8, t+12 with tx_start only at t; rsp[0..2]=5C,42,02; done at t+16.
REQ-039 cmd=0x02, len=3, payload 0x80,0x01,0xFF -> tx_data sequence 02,80,01,FF; single tx_start pulse; busy low after done.
REQ-040 req_len=12 -> exactly 8 payload strobes; rsp[7] captured.
REQ-041 Reset asserted on the cycle after the second strobe -> no further strobes, done never pulses, all outputs 0.
REQ-042 IRQPOLL_EN, int_n=0, responder status 0x01 -> frame 05,00; irq_status=0x01; next poll sends 05,01.
REQ-043 IRQPOLL_EN, int_n=0 and req_valid=1 on the same cycle -> user frame is sent first, then the poll.

Source files
------------

// File: rtl/sysctrl_master_if.sv
// Bus bundle for sysctrl_master: request handshake, payload/response buffer
// ports, byte link to the responder and interrupt status.
// master = the sysctrl_master block, slave = the host/responder environment.
interface sysctrl_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cmd;
    logic [3:0] req_len;
    logic       pl_we;
    logic [2:0] pl_addr;
    logic [7:0] pl_wdata;
    logic [2:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       tx_strobe;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       int_n;
    logic [7:0] irq_status;
    logic       irq_valid;

    modport master (
        input  req_valid, req_cmd, req_len, pl_we, pl_addr, pl_wdata,
               rsp_addr, rx_data, int_n,
        output req_ready, rsp_rdata, tx_strobe, tx_start, tx_data,
               busy, done, irq_status, irq_valid
    );

    modport slave (
        output req_valid, req_cmd, req_len, pl_we, pl_addr, pl_wdata,
               rsp_addr, rx_data, int_n,
        input  req_ready, rsp_rdata, tx_strobe, tx_start, tx_data,
               busy, done, irq_status, irq_valid
    );
endinterface

// File: rtl/sysctrl_master.sv
// sysctrl_master: issues command frames (command byte + up to 8 payload
// bytes) to a responder as byte strobes spaced exactly GAP clocks apart and
// captures one returned byte per payload byte into an 8-entry response buffer.
// Optional feature macro SYSCTRL_MASTER_IRQPOLL_EN: while idle with int_n low
// the block autonomously polls (cmd 8'h05, one payload byte = last status) and
// publishes the returned byte on irq_status/irq_valid.
module sysctrl_master #(
    parameter int unsigned GAP = 4   // 2..15
) (
    input logic       clk,
    input logic       reset,
    sysctrl_master_if.master bus
);

    // The response capture for a data byte is folded into the WAIT expiry
    // edge: that edge is GAP clocks after the byte's strobe edge, the same
    // edge that launches the next strobe or done, so no extra cycle is spent.
    typedef enum logic [2:0] {IDLE, CMD, WAIT, DATA, FIN} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] len;
    logic [3:0] k;          // index of the last payload byte strobed
    logic       is_data;    // last strobe was a payload byte (needs capture)
    logic       poll;       // current frame is an autonomous poll
    logic       tx_strobe;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] irq_stat;
    logic       irq_pulse;
    logic       poll_start;

    logic [7:0] pl  [8];
    logic [7:0] rsp [8];

    logic       hs;
    logic [3:0] len_in;
    logic [3:0] k_next;
    logic [7:0] next_byte;

    assign hs        = bus.req_valid && bus.req_ready;
    assign len_in    = (bus.req_len > 4'd8) ? 4'd8 : bus.req_len;
    assign k_next    = is_data ? k + 4'd1 : k;
    assign next_byte = poll ? irq_stat : pl[k_next[2:0]];

`ifdef SYSCTRL_MASTER_IRQPOLL_EN
    logic [3:0] holdoff;    // clocks left before a poll may start after done

    assign poll_start = (state == IDLE) && !bus.int_n && !bus.req_valid &&
                        (holdoff == 4'd0);
`else
    logic unused_int_n;

    assign unused_int_n = bus.int_n;
    assign poll_start   = 1'b0;
    assign irq_stat     = 8'h00;
    assign irq_pulse    = 1'b0;
`endif

    assign bus.req_ready  = (state == IDLE) && !poll_start;
    assign bus.rsp_rdata  = rsp[bus.rsp_addr];
    assign bus.tx_strobe  = tx_strobe;
    assign bus.tx_start   = tx_start;
    assign bus.tx_data    = tx_data;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.irq_status = irq_stat;
    assign bus.irq_valid  = irq_pulse;

    // Payload buffer: host writes land only while no frame is running, so a
    // frame always sends the contents present at its handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) pl[i] <= 8'h00;
        end else if (bus.pl_we && !busy) begin
            pl[bus.pl_addr] <= bus.pl_wdata;
        end
    end

    // Frame sequencer with registered strobe/done outputs and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            len       <= 4'd0;
            k         <= 4'd0;
            is_data   <= 1'b0;
            poll      <= 1'b0;
            tx_strobe <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 8; i++) rsp[i] <= 8'h00;
`ifdef SYSCTRL_MASTER_IRQPOLL_EN
            irq_stat  <= 8'h00;
            irq_pulse <= 1'b0;
            holdoff   <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SYSCTRL_MASTER_IRQPOLL_EN
            irq_pulse <= 1'b0;
            if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;
`endif
            case (state)
                IDLE: begin
                    if (hs || poll_start) begin
                        state     <= CMD;
                        busy      <= 1'b1;
                        tx_strobe <= 1'b1;
                        tx_start  <= 1'b1;
                        k         <= 4'd0;
                        is_data   <= 1'b0;
                        if (hs) begin
                            tx_data <= bus.req_cmd;
                            len     <= len_in;
                            poll    <= 1'b0;
                        end else begin
                            tx_data <= 8'h05;
                            len     <= 4'd1;
                            poll    <= 1'b1;
                        end
                    end
                end
                CMD, DATA: begin
                    tx_strobe <= 1'b0;
                    tx_start  <= 1'b0;
                    tx_data   <= 8'h00;
                    cnt       <= 4'(GAP - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (is_data) begin
                            rsp[k[2:0]] <= bus.rx_data;
`ifdef SYSCTRL_MASTER_IRQPOLL_EN
                            if (poll) irq_stat <= bus.rx_data;
`endif
                        end
                        if (k_next < len) begin
                            state     <= DATA;
                            k         <= k_next;
                            is_data   <= 1'b1;
                            tx_strobe <= 1'b1;
                            tx_data   <= next_byte;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
`ifdef SYSCTRL_MASTER_IRQPOLL_EN
                            irq_pulse <= poll;
                            holdoff   <= 4'(GAP);
`endif
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    poll  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysctrl_master.sv
// Directed bench for sysctrl_master (GAP=4): strobe timing, payload/response
// buffers, length clamp, len=0, mid-frame reset and, when
// SYSCTRL_MASTER_IRQPOLL_EN is defined, the autonomous interrupt poll.
module tb_sysctrl_master;
    localparam int GAP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sysctrl_master_if bus();
    sysctrl_master #(.GAP(GAP)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    int checks = 0;
    int errors = 0;

    // cycle index: after the posedge that starts cycle c, cyc == c
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // strobe log and responder model
    int         s_cyc[$];
    logic [7:0] s_dat[$];
    logic       s_st[$];
    int         done_cnt = 0, last_done = -1, irqv_cnt = 0;
    int         adj_err = 0, txd_err = 0, rx_idx = 0;
    logic       prev_stb = 1'b0;
    logic [7:0] resp_tab [8];
    logic [7:0] rx_byte = 8'h00;

    assign bus.rx_data = rx_byte;

    // Observe on the falling edge; the responder answers each payload byte
    // from resp_tab in order, holding the byte until the next strobe.
    always @(negedge clk) begin
        if (bus.tx_strobe) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(bus.tx_data);
            s_st.push_back(bus.tx_start);
            if (prev_stb) adj_err++;
            if (bus.tx_start) rx_idx = 0;
            else begin
                rx_byte = resp_tab[rx_idx[2:0]];
                rx_idx++;
            end
        end else if (bus.tx_data != 8'h00) begin
            txd_err++;
        end
        prev_stb = bus.tx_strobe;
        if (bus.done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (bus.irq_valid) irqv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_pl(input logic [2:0] a, input logic [7:0] d);
        bus.pl_we = 1'b1; bus.pl_addr = a; bus.pl_wdata = d;
        tick(1);
        bus.pl_we = 1'b0;
    endtask

    task automatic rd_rsp(input logic [2:0] a, output logic [7:0] d);
        bus.rsp_addr = a;
        #1 d = bus.rsp_rdata;
    endtask

    // drive a request for one cycle; h = cycle in which the handshake occurs
    task automatic start(input logic [7:0] c, input logic [3:0] l, output int h);
        chk("ready_before_req", bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_cmd = c; bus.req_len = l;
        h = cyc;
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 300) begin tick(1); n++; end
        if (n >= 300) chk("done_timeout", 0, 1);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int h, n0, d0, n;
        logic [7:0] r;
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        bus.req_valid = 0; bus.req_cmd = 0; bus.req_len = 0;
        bus.pl_we = 0; bus.pl_addr = 0; bus.pl_wdata = 0;
        bus.rsp_addr = 0; bus.int_n = 1'b1;
        for (int i = 0; i < 8; i++) resp_tab[i] = 8'h00;

        // reset state
        reset = 1'b1; tick(3); reset = 1'b0; tick(1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_stb", bus.tx_strobe, 0);
        chk("rst_start", bus.tx_start, 0);
        chk("rst_txd", bus.tx_data, 0);
        chk("rst_irq_status", bus.irq_status, 0);
        chk("rst_irq_valid", bus.irq_valid, 0);
        chk("rst_ready", bus.req_ready, 1);
        rd_rsp(0, r); chk("rst_rsp0", r, 0);
        rd_rsp(7, r); chk("rst_rsp7", r, 0);
        tick(1);

        // frame A: cmd 00, len 3, responder 5C/42/02
        wr_pl(0, 8'hAA); wr_pl(1, 8'hBB); wr_pl(2, 8'hCC);
        resp_tab[0] = 8'h5C; resp_tab[1] = 8'h42; resp_tab[2] = 8'h02;
        exp_a = '{8'h00, 8'hAA, 8'hBB, 8'hCC};
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h00, 4'd3, h);
        wait_done(d0);
        chk("a_nstb", s_cyc.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < s_cyc.size()) begin
                chk("a_stb_cyc", s_cyc[n0+i], h + 1 + GAP*i);
                chk("a_stb_start", s_st[n0+i], (i == 0) ? 1 : 0);
                chk("a_stb_data", s_dat[n0+i], exp_a[i]);
            end
        end
        chk("a_done_cyc", last_done, h + 1 + 4*GAP);
        chk("a_busy_after", bus.busy, 0);
        rd_rsp(0, r); chk("a_rsp0", r, 8'h5C);
        rd_rsp(1, r); chk("a_rsp1", r, 8'h42);
        rd_rsp(2, r); chk("a_rsp2", r, 8'h02);
        tick(1);

        // frame B: cmd 02, payload 80/01/FF
        wr_pl(0, 8'h80); wr_pl(1, 8'h01); wr_pl(2, 8'hFF);
        exp_b = '{8'h02, 8'h80, 8'h01, 8'hFF};
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h02, 4'd3, h);
        wait_done(d0);
        chk("b_nstb", s_cyc.size() - n0, 4);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < s_cyc.size()) begin
                chk("b_stb_data", s_dat[n0+i], exp_b[i]);
                if (s_st[n0+i]) n++;
            end
        end
        chk("b_nstart", n, 1);
        chk("b_busy_after", bus.busy, 0);

        // frame C: req_len 12 clamps to 8
        for (int i = 0; i < 8; i++) begin
            wr_pl(3'(i), 8'h10 + 8'(i));
            resp_tab[i] = 8'hA0 + 8'(i);
        end
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h03, 4'd12, h);
        wait_done(d0);
        chk("c_nstb", s_cyc.size() - n0, 9);
        if (n0 + 8 < s_cyc.size()) chk("c_last_data", s_dat[n0+8], 8'h17);
        chk("c_done_cyc", last_done, h + 1 + 9*GAP);
        rd_rsp(0, r); chk("c_rsp0", r, 8'hA0);
        rd_rsp(7, r); chk("c_rsp7", r, 8'hA7);
        tick(1);

        // frame D: len 2, payload write while busy is dropped, rsp[2..] kept
        resp_tab[0] = 8'h11; resp_tab[1] = 8'h22;
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h04, 4'd2, h);
        tick(2);
        wr_pl(1, 8'hEE);
        wait_done(d0);
        chk("d_nstb", s_cyc.size() - n0, 3);
        if (n0 + 2 < s_cyc.size()) chk("d_byte1", s_dat[n0+2], 8'h11);
        rd_rsp(0, r); chk("d_rsp0", r, 8'h11);
        rd_rsp(1, r); chk("d_rsp1", r, 8'h22);
        rd_rsp(2, r); chk("d_rsp2_kept", r, 8'hA2);
        rd_rsp(7, r); chk("d_rsp7_kept", r, 8'hA7);
        tick(1);

        // frame E: len 0 -> command strobe only, done GAP+1 after handshake
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h06, 4'd0, h);
        wait_done(d0);
        chk("e_nstb", s_cyc.size() - n0, 1);
        chk("e_done_cyc", last_done, h + GAP + 1);

        // frame F: dropped write must not have reached the buffer
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h07, 4'd2, h);
        wait_done(d0);
        if (n0 + 2 < s_cyc.size()) chk("f_byte1", s_dat[n0+2], 8'h11);
        else chk("f_nstb", s_cyc.size() - n0, 3);

        // reset in the cycle after the second strobe
        n0 = s_cyc.size(); d0 = done_cnt;
        start(8'h09, 4'd3, h);
        tick(5);
        chk("r_pre_nstb", s_cyc.size() - n0, 2);
        reset = 1'b1; tick(2); reset = 1'b0;
        tick(40);
        chk("r_nstb", s_cyc.size() - n0, 2);
        chk("r_no_done", done_cnt, d0);
        chk("r_busy", bus.busy, 0);
        chk("r_stb", bus.tx_strobe, 0);
        chk("r_txd", bus.tx_data, 0);
        rd_rsp(0, r); chk("r_rsp0", r, 0);
        tick(1);

`ifdef SYSCTRL_MASTER_IRQPOLL_EN
        // two polls: first acks 00, second acks the captured 01
        resp_tab[0] = 8'h01;
        n0 = s_cyc.size(); d0 = irqv_cnt;
        bus.int_n = 1'b0;
        n = 0;
        while (s_cyc.size() < n0 + 4 && n < 300) begin tick(1); n++; end
        bus.int_n = 1'b1;
        n = 0;
        while ((bus.busy || bus.done) && n < 300) begin tick(1); n++; end
        tick(2);
        chk("p_nstb", s_cyc.size() - n0, 4);
        if (n0 + 3 < s_cyc.size()) begin
            chk("p_cmd0", s_dat[n0], 8'h05);
            chk("p_ack0", s_dat[n0+1], 8'h00);
            chk("p_cmd1", s_dat[n0+2], 8'h05);
            chk("p_ack1", s_dat[n0+3], 8'h01);
        end
        chk("p_irq_status", bus.irq_status, 8'h01);
        chk("p_irq_valid_cnt", irqv_cnt - d0, 2);
        tick(GAP + 2);

        // user request and interrupt on the same cycle: user goes first
        n0 = s_cyc.size();
        bus.int_n = 1'b0;
        start(8'h33, 4'd0, h);
        n = 0;
        while (s_cyc.size() < n0 + 2 && n < 300) begin tick(1); n++; end
        bus.int_n = 1'b1;
        n = 0;
        while ((bus.busy || bus.done) && n < 300) begin tick(1); n++; end
        tick(2);
        if (n0 + 1 < s_cyc.size()) begin
            chk("q_user_first", s_dat[n0], 8'h33);
            chk("q_poll_second", s_dat[n0+1], 8'h05);
        end else chk("q_nstb", s_cyc.size() - n0, 3);
`else
        // feature off: interrupt line ignored
        n0 = s_cyc.size(); d0 = irqv_cnt;
        bus.int_n = 1'b0;
        tick(30);
        chk("n_ready", bus.req_ready, 1);
        bus.int_n = 1'b1;
        chk("n_nstb", s_cyc.size() - n0, 0);
        chk("n_irq_status", bus.irq_status, 0);
        chk("n_irq_valid", irqv_cnt - d0, 0);
`endif

        chk("adjacent_strobes", adj_err, 0);
        chk("txdata_idle_zero", txd_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
